// File: rtl/controller_iram_arbiter.sv
// controller_iram_arbiter: two-port (instruction m0 / debug m1) arbiter onto a single-ported IRAM; optional IRAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed m0 priority
module controller_iram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 10240
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [31:0]       m1_writedata,
   input  logic [3:0]        m1_byteenable,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic              ram_debugaccess,
   output logic [31:0]       ram_writedata,
   output logic              ram_clken,
   input  logic [31:0]       ram_readdata,
   output logic              oor_err
);
   logic m0_act, m1_act, prio_m0, gnt_m0, gnt_m1, gnt, m1_wr, oor, rd;
   logic [ADDR_W-1:0] sel_addr;
   logic last_grant_q, rd_pend_q, rd_owner_q, rd_oor_q, clken_q, oor_err_q;

   // Grant selection and combinational steering of the winner onto the RAM port
   always_comb begin
      m0_act = m0_read;
      m1_act = m1_read | m1_write;
`ifdef IRAM_ARB_ROUND_ROBIN_EN
      prio_m0 = last_grant_q;
`else
      prio_m0 = 1'b1 | last_grant_q;
`endif
      gnt_m0 = ~reset & m0_act & (~m1_act | prio_m0);
      gnt_m1 = ~reset & m1_act & ~gnt_m0;
      gnt = gnt_m0 | gnt_m1;
      m1_wr = gnt_m1 & m1_write;
      sel_addr = gnt_m1 ? m1_address : m0_address;
      oor = gnt & ({{(32-ADDR_W){1'b0}}, sel_addr} >= 32'(DEPTH));
      rd = gnt & ~m1_wr;
      m0_waitrequest = ~reset & m0_act & ~gnt_m0;
      m1_waitrequest = ~reset & m1_act & ~gnt_m1;
      ram_address = gnt ? sel_addr : '0;
      ram_chipselect = gnt & ~oor;
      ram_write = m1_wr & ~oor;
      ram_debugaccess = m1_wr & ~oor;
      ram_byteenable = ~gnt ? 4'h0 : m1_wr ? m1_byteenable : 4'hF;
      ram_writedata = m1_wr ? m1_writedata : 32'h0;
      ram_clken = clken_q;
      m0_readdatavalid = rd_pend_q & ~rd_owner_q;
      m1_readdatavalid = rd_pend_q & rd_owner_q;
      m0_readdata = (m0_readdatavalid & ~rd_oor_q) ? ram_readdata : 32'h0;
      m1_readdata = (m1_readdatavalid & ~rd_oor_q) ? ram_readdata : 32'h0;
      oor_err = oor_err_q;
   end

   // Read-return tracking, last winner, clock enable and sticky out-of-range flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         rd_pend_q <= 1'b0;
         rd_owner_q <= 1'b0;
         rd_oor_q <= 1'b0;
         clken_q <= 1'b0;
         oor_err_q <= 1'b0;
      end else begin
         clken_q <= 1'b1;
         rd_pend_q <= rd;
         rd_owner_q <= gnt_m1;
         rd_oor_q <= oor;
         if (gnt) last_grant_q <= gnt_m1;
         if (oor) oor_err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_controller_iram_arbiter.sv
// tb_controller_iram_arbiter: table vectors, directed corner sequences and randomized traffic against a reference model
module tb_controller_iram_arbiter;
   localparam int AW = 14;
   localparam int DEPTH = 10240;
`ifdef IRAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1;
   logic [AW-1:0] m0_address = '0, m1_address = '0, ram_address;
   logic m0_read = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m1_writedata = '0, m0_readdata, m1_readdata, ram_writedata, ram_readdata = '0;
   logic [3:0] m1_byteenable = '0, ram_byteenable;
   logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
   logic ram_chipselect, ram_write, ram_debugaccess, ram_clken, oor_err;

   always #5 clk = ~clk;

   controller_iram_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_debugaccess(ram_debugaccess), .ram_writedata(ram_writedata),
      .ram_clken(ram_clken), .ram_readdata(ram_readdata), .oor_err(oor_err)
   );

   function automatic logic [31:0] init_val(input int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   // Synchronous single-port RAM: data of the sampled address appears the next cycle
   logic [31:0] mem [0:16383];
   initial for (int i = 0; i < 16384; i++) mem[i] = init_val(i);
   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write)
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         ram_readdata <= mem[ram_address];
      end
   end

   int checks = 0, errors = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   logic [31:0] refm [0:16383];
   bit last = 1'b1, pv = 1'b0, po = 1'b0, oor_m = 1'b0, up = 1'b0, g0_l = 1'b0, g1_l = 1'b0;
   logic [31:0] pd = '0;
   logic w0_s, w1_s, v0_s, v1_s, cs_s, we_s, dbg_s, oor_s, ck_s;
   logic [31:0] d0_s, d1_s, wd_s;
   logic [3:0] be_s;
   logic [AW-1:0] addr_s;

   // One clock cycle: inputs already applied at the falling edge; sample, check, advance the model
   task automatic cyc();
      bit a0, a1, g0, g1, wr, rd, ox;
      logic [AW-1:0] ad;
      #1;
      {w0_s, w1_s, v0_s, v1_s, cs_s, we_s, dbg_s, oor_s, ck_s} =
         {m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
          ram_chipselect, ram_write, ram_debugaccess, oor_err, ram_clken};
      d0_s = m0_readdata; d1_s = m1_readdata; be_s = ram_byteenable; addr_s = ram_address; wd_s = ram_writedata;
      if (reset) begin
         chk("rst_w0", 32'(w0_s), 0); chk("rst_w1", 32'(w1_s), 0);
         chk("rst_v0", 32'(v0_s), 0); chk("rst_v1", 32'(v1_s), 0);
         chk("rst_d0", d0_s, 0); chk("rst_d1", d1_s, 0);
         chk("rst_cs", 32'(cs_s), 0); chk("rst_we", 32'(we_s), 0); chk("rst_dbg", 32'(dbg_s), 0);
         chk("rst_be", 32'(be_s), 0); chk("rst_addr", 32'(addr_s), 0); chk("rst_wd", wd_s, 0);
         chk("rst_clken", 32'(ck_s), 0); chk("rst_oor", 32'(oor_s), 0);
         last = 1'b1; pv = 1'b0; oor_m = 1'b0; up = 1'b0; g0_l = 1'b0; g1_l = 1'b0;
      end else begin
         chk("m0_rdv", 32'(v0_s), 32'(pv && !po)); chk("m0_rdata", d0_s, (pv && !po) ? pd : 32'h0);
         chk("m1_rdv", 32'(v1_s), 32'(pv && po)); chk("m1_rdata", d1_s, (pv && po) ? pd : 32'h0);
         chk("oor_err", 32'(oor_s), 32'(oor_m)); chk("ram_clken", 32'(ck_s), 32'(up));
         a0 = m0_read; a1 = m1_read | m1_write;
         if (a0 && a1) begin g0 = RR ? last : 1'b1; g1 = !g0; end
         else begin g0 = a0; g1 = a1; end
         ad = g1 ? m1_address : m0_address;
         wr = g1 && m1_write;
         rd = (g0 || g1) && !wr;
         ox = (g0 || g1) && int'(ad) >= DEPTH;
         chk("m0_wait", 32'(w0_s), 32'(a0 && !g0)); chk("m1_wait", 32'(w1_s), 32'(a1 && !g1));
         chk("ram_cs", 32'(cs_s), 32'((g0 || g1) && !ox));
         chk("ram_we", 32'(we_s), 32'(wr && !ox)); chk("ram_dbg", 32'(dbg_s), 32'(wr && !ox));
         if ((g0 || g1) && !ox) begin
            chk("ram_addr", 32'(addr_s), 32'(ad));
            chk("ram_be", 32'(be_s), wr ? 32'(m1_byteenable) : 32'hF);
         end
         if (wr && !ox) begin
            chk("ram_wd", wd_s, m1_writedata);
            for (int b = 0; b < 4; b++)
               if (m1_byteenable[b]) refm[ad][8*b +: 8] = m1_writedata[8*b +: 8];
         end
         pv = rd; po = g1; pd = ox ? 32'h0 : refm[ad];
         if (ox) oor_m = 1'b1;
         if (g0 || g1) last = g1;
         up = 1'b1; g0_l = g0; g1_l = g1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      m0_read = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic do_reset();
      idle(); reset = 1; cyc(); cyc(); reset = 0; cyc();
   endtask

   function automatic logic [AW-1:0] raddr();
      return ($urandom_range(0, 31) == 0) ? AW'(DEPTH + int'($urandom_range(0, 50))) : AW'($urandom_range(0, 15));
   endfunction

   typedef struct {
      bit r0; logic [AW-1:0] a0; bit r1, w1; logic [AW-1:0] a1; logic [31:0] wd; logic [3:0] be;
      bit ew0, ew1, ecs, ewe; logic [3:0] ebe; logic [AW-1:0] ead;
   } vec_t;
   vec_t tbl [5];

   initial begin
      logic [31:0] iv;
      bit ew0, ew1;
      for (int i = 0; i < 16384; i++) refm[i] = init_val(i);
      tbl[0] = '{1'b1, 14'd3, 1'b0, 1'b0, 14'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 14'd3};
      tbl[1] = '{1'b0, 14'd0, 1'b1, 1'b0, 14'd7, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 14'd7};
      tbl[2] = '{1'b0, 14'd0, 1'b0, 1'b1, 14'd9, 32'h11223344, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 14'd9};
      tbl[3] = '{1'b0, 14'd0, 1'b1, 1'b1, 14'd4, 32'hCAFEF00D, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC, 14'd4};
      tbl[4] = '{1'b1, 14'd10240, 1'b0, 1'b0, 14'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 14'd0};
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 5; i++) begin
         m0_read = tbl[i].r0; m0_address = tbl[i].a0; m1_read = tbl[i].r1; m1_write = tbl[i].w1;
         m1_address = tbl[i].a1; m1_writedata = tbl[i].wd; m1_byteenable = tbl[i].be;
         cyc();
         chk("tbl_w0", 32'(w0_s), 32'(tbl[i].ew0)); chk("tbl_w1", 32'(w1_s), 32'(tbl[i].ew1));
         chk("tbl_cs", 32'(cs_s), 32'(tbl[i].ecs)); chk("tbl_we", 32'(we_s), 32'(tbl[i].ewe));
         chk("tbl_dbg", 32'(dbg_s), 32'(tbl[i].ewe));
         if (tbl[i].ecs) begin
            chk("tbl_be", 32'(be_s), 32'(tbl[i].ebe)); chk("tbl_addr", 32'(addr_s), 32'(tbl[i].ead));
         end
      end
      idle(); cyc();
      chk("tbl_oor_sticky", 32'(oor_s), 1);

      do_reset();
      for (int k = 0; k < 3; k++) begin
         m0_read = 1; m0_address = AW'(k); cyc();
         chk("b2b_wait", 32'(w0_s), 0);
         if (k > 0) begin chk("b2b_rdv", 32'(v0_s), 1); chk("b2b_data", d0_s, init_val(k - 1)); end
      end
      idle(); cyc();
      chk("b2b_rdv_last", 32'(v0_s), 1); chk("b2b_data_last", d0_s, init_val(2));
      cyc();
      chk("b2b_rdv_end", 32'(v0_s), 0);

      m1_write = 1; m1_address = 5; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011; cyc();
      chk("dbg_write", 32'(dbg_s), 1); chk("dbg_write_v1", 32'(v1_s), 0);
      m1_write = 0; m1_read = 1; cyc();
      chk("dbg_read", 32'(dbg_s), 0);
      idle(); cyc();
      iv = init_val(5);
      chk("be_merge_rdv", 32'(v1_s), 1); chk("be_merge_data", d1_s, {iv[31:16], 16'hBEEF});

      do_reset();
      m0_read = 1; m0_address = 1; m1_read = 1; m1_address = 2;
      for (int k = 0; k < 6; k++) begin
         ew0 = RR ? k[0] : 1'b0; ew1 = RR ? !k[0] : 1'b1;
         cyc();
         chk("cont_w0", 32'(w0_s), 32'(ew0)); chk("cont_w1", 32'(w1_s), 32'(ew1));
      end
      idle(); cyc();

      m1_read = 1; m1_address = 14'd10240; cyc();
      chk("oor_cs", 32'(cs_s), 0); chk("oor_wait", 32'(w1_s), 0);
      m1_read = 0; m0_read = 1; m0_address = 3; cyc();
      chk("oor_rdv", 32'(v1_s), 1); chk("oor_data", d1_s, 0); chk("oor_flag", 32'(oor_s), 1);
      for (int k = 0; k < 3; k++) begin m0_address = AW'(k); cyc(); end
      idle(); cyc();
      chk("oor_held", 32'(oor_s), 1);

      do_reset();
      m0_read = 1; m0_address = 7; cyc();
      reset = 1; cyc();
      chk("midrd_rdv", 32'(v0_s), 0); chk("midrd_wait", 32'(w0_s), 0); chk("midrd_cs", 32'(cs_s), 0);
      reset = 0; m1_read = 1; m1_address = 8; cyc();
      chk("post_rst_w0", 32'(w0_s), 0); chk("post_rst_w1", 32'(w1_s), 1); chk("post_rst_rdv", 32'(v0_s), 0);
      idle(); cyc(); cyc();

      do_reset();
      for (int n = 0; n < 600; n++) begin
         if (!m0_read || g0_l) begin
            m0_read = $urandom_range(0, 2) != 0; m0_address = raddr();
         end
         if (!(m1_read || m1_write) || g1_l) begin
            {m1_write, m1_read} = 2'($urandom_range(0, 3));
            m1_address = raddr(); m1_writedata = $urandom; m1_byteenable = 4'($urandom_range(0, 15));
         end
         reset = $urandom_range(0, 149) == 0;
         cyc();
      end
      reset = 0; idle(); cyc(); cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/controller_iram_arbiter.md
CONTROLLER_IRAM_ARBITER -- requirements
Module: controller_iram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, RAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 10240, number of implemented 32-bit words.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `reset` (in, 1), with one clock; reset is asynchronous and active-high.
REQ-004 SHALL have instruction port m0 (read-only):
- `m0_address` in ADDR_W
- `m0_read` in 1
- `m0_waitrequest` out 1
- `m0_readdata` out 32
- `m0_readdatavalid` out 1
REQ-005 SHALL have debug port m1:
- `m1_address` in ADDR_W
- `m1_read` in 1
- `m1_write` in 1
- `m1_writedata` in 32
- `m1_byteenable` in 4
- `m1_waitrequest` out 1
- `m1_readdata` out 32
- `m1_readdatavalid` out 1
REQ-006 SHALL have RAM port:
- `ram_address` out ADDR_W
- `ram_byteenable` out 4
- `ram_chipselect` out 1
- `ram_write` out 1
- `ram_debugaccess` out 1
- `ram_writedata` out 32
- `ram_clken` out 1
- `ram_readdata` in 32 (valid the cycle after address is sampled)
REQ-007 SHALL have `oor_err` out 1, a sticky out-of-range flag.

Function
REQ-008 SHALL issue at most one RAM access per cycle, to the granted requester only.
REQ-009 SHALL treat a requester as active when m0_read, or m1_read|m1_write, is high; with m1_read and m1_write both high, it SHALL perform the write and ignore the read.
REQ-010 SHALL drive mX_waitrequest combinationally as (active & ~granted); an ungranted requester holds its request until waitrequest is low.
REQ-011 SHALL, when only one requester is active, grant it in the same cycle, with zero wait.
REQ-012 SHALL resolve conflicts per REQ-025/026 and record the winner in a last_grant register.
REQ-013 SHALL drive the RAM signals combinationally from the granted port:
- ram_chipselect=1; ram_write=1 only for an m1 write
- ram_debugaccess=1 only for an m1 write
- ram_byteenable=m1_byteenable on an m1 write, else 4'hF
REQ-014 SHALL hold ram_clken at 1 after reset.
REQ-015 SHALL give reads a latency of exactly 1: a read granted in cycle N asserts the owner's readdatavalid for one cycle in N+1, with readdata=ram_readdata; the owner is tracked in registers rd_pend_q/rd_owner_q.
REQ-016 SHALL accept back-to-back reads every cycle, with no bubble and no reordering.
REQ-017 SHALL hold a non-owner's readdata at 0 and its readdatavalid at 0.
REQ-018 SHALL handle an address >= DEPTH as follows:
- grant normally, with ram_chipselect=0 and ram_write=0
- a read returns readdatavalid in N+1 with data 32'h0
- set oor_err, which stays set until reset
REQ-019 SHALL produce no readdatavalid for writes; a write completes in its grant cycle.

Reset
REQ-020 SHALL, while reset is high, force all outputs low: waitrequests, readdatavalids, readdata, ram_* and oor_err.
REQ-021 SHALL set last_grant=m1 on reset, so that m0 wins the first conflict.
REQ-022 SHALL, on reset asserted mid-read, clear rd_pend_q immediately; the pending readdatavalid is never produced.
REQ-023 SHALL drive ram_clken=0 during reset and 1 from the first clock edge after reset deasserts.
REQ-024 SHALL grant no request in the cycle reset is high.

Configuration
REQ-025 SHALL, with IRAM_ARB_ROUND_ROBIN_EN defined, grant the requester not in last_grant on conflict, alternating under sustained contention.
REQ-026 SHALL, without IRAM_ARB_ROUND_ROBIN_EN, always grant m0 on conflict (fixed priority); m1 then waits until m0 idles; last_grant is still updated but unused.

Verification
REQ-027 SHALL pass: m0 reads addr 0,1,2 on consecutive cycles -> m0_readdatavalid high 3 consecutive cycles starting N+1, data = RAM[0..2], waitrequest always 0.
REQ-028 SHALL pass: m1 writes 32'hDEADBEEF, be=4'b0011, addr 5, then m1 reads addr 5 -> ram_debugaccess=1 only in the write cycle; read returns 32'h????BEEF with upper bytes = prior contents.
REQ-029 SHALL pass: m0 and m1 reading continuously for 6 cycles -> with RR_EN grants m0,m1,m0,m1,m0,m1; without it, m0 for 6 cycles with m1_waitrequest=1 throughout.
REQ-030 SHALL pass: m1 reads addr 10240 -> ram_chipselect=0, m1_readdatavalid in N+1 with 0, oor_err=1 and held after further legal traffic.
REQ-031 SHALL pass: reset asserted the cycle after an m0 read grant -> no m0_readdatavalid, all outputs 0; the first conflict after reset is granted to m0.
